// File: rtl/prog_loader.sv
// Loadable program RAM with a byte-stream loader, sitting in front of the CPU address bus.
// Optional build macro PROG_LOADER_CHECKSUM_EN adds a trailing checksum byte and ERR reporting.
module prog_loader #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          CLEARn,
    input  logic          START,
    input  logic [DW-1:0] IN_DATA,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] OUT,
    input  logic          HALT,
    output logic          RUN,
    output logic          BUSY,
    output logic          DONE,
    output logic          ERR,
    output logic [AW:0]   COUNT
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LOAD,
        S_RUN
`ifdef PROG_LOADER_CHECKSUM_EN
        , S_CSUM
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [AW:0]   len_q, len_d;
    logic [AW:0]   count_q, count_d;
    logic          we;
    logic          ready, busy, done;
    logic [DW-1:0] mem_q [2**AW];

`ifdef PROG_LOADER_CHECKSUM_EN
    logic          err_q, err_d;
    logic [DW-1:0] sum_q, sum_d;
    logic [DW-1:0] sum_nxt;
    assign sum_nxt = sum_q + IN_DATA;
`endif

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        count_d = count_q;
        we      = 1'b0;
        ready   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
        err_d   = err_q;
        sum_d   = sum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d = S_HDR;
`ifdef PROG_LOADER_CHECKSUM_EN
                    err_d   = 1'b0;
                    sum_d   = '0;
`endif
                end
            end
            S_HDR: begin
                ready = 1'b1;
                busy  = 1'b1;
                if (IN_VALID) begin
                    // A zero header encodes the full 2^AW depth.
                    if (IN_DATA == '0) len_d = {1'b1, {AW{1'b0}}};
                    else               len_d = (AW+1)'(IN_DATA);
                    count_d = '0;
                    state_d = S_LOAD;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_d   = IN_DATA;
`endif
                end
            end
            S_LOAD: begin
                ready = 1'b1;
                busy  = 1'b1;
                if (IN_VALID) begin
                    we      = 1'b1;
                    count_d = count_q + (AW+1)'(1);
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_d   = sum_nxt;
                    if (count_d == len_q) state_d = S_CSUM;
`else
                    if (count_d == len_q) state_d = S_RUN;
`endif
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CSUM: begin
                ready = 1'b1;
                busy  = 1'b1;
                if (IN_VALID) begin
                    if (sum_nxt == '0) begin
                        state_d = S_RUN;
                    end else begin
                        err_d   = 1'b1;
                        len_d   = '0;
                        state_d = S_IDLE;
                    end
                end
            end
`endif
            S_RUN: begin
                done = 1'b1;
                if (START) begin
                    state_d = S_HDR;
`ifdef PROG_LOADER_CHECKSUM_EN
                    err_d   = 1'b0;
                    sum_d   = '0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge CLEARn) begin
        if (!CLEARn) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            count_q <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            err_q   <= 1'b0;
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            count_q <= count_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            err_q   <= err_d;
            sum_q   <= sum_d;
`endif
        end
    end

    // RAM survives reset; LEN=0 alone hides stale contents.
    always_ff @(posedge clk) begin
        if (we) mem_q[count_q[AW-1:0]] <= IN_DATA;
    end

    assign OUT      = ({1'b0, addr} < len_q) ? mem_q[addr] : '0;
    assign RUN      = (state_q == S_RUN) & ~HALT;
    assign IN_READY = ready;
    assign BUSY     = busy;
    assign DONE     = done;
    assign COUNT    = count_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    assign ERR      = err_q;
`else
    assign ERR      = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader; checksum steps compile in with PROG_LOADER_CHECKSUM_EN.
module tb_prog_loader;
    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          CLEARn, START, IN_VALID, HALT;
    logic [DW-1:0] IN_DATA;
    logic [AW-1:0] addr;
    logic          IN_READY, RUN, BUSY, DONE, ERR;
    logic [DW-1:0] OUT;
    logic [AW:0]   COUNT;

    int            tests = 0;
    int            fails = 0;
    logic [7:0]    tb_sum;

    prog_loader #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .CLEARn(CLEARn), .START(START), .IN_DATA(IN_DATA),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .addr(addr), .OUT(OUT),
        .HALT(HALT), .RUN(RUN), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .COUNT(COUNT)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic [7:0] b);
        IN_DATA  = b;
        IN_VALID = 1'b1;
        chk("in_ready", {31'b0, IN_READY}, 32'd1);
        tb_sum   = tb_sum + b;
        tick();
        IN_VALID = 1'b0;
    endtask

    task automatic start_load();
        START  = 1'b1;
        tick();
        START  = 1'b0;
        tb_sum = 8'h00;
    endtask

    task automatic finish_load();
`ifdef PROG_LOADER_CHECKSUM_EN
        logic [7:0] c;
        c = 8'h00 - tb_sum;
        xfer(c);
`endif
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
        addr = a;
        #1;
        chk(tag, {24'b0, OUT}, {24'b0, exp});
    endtask

    initial begin
        CLEARn = 1'b0; START = 1'b0; IN_VALID = 1'b0; IN_DATA = '0; addr = '0; HALT = 1'b0;
        tb_sum = 8'h00;
        #3;
        chk("rst_run",   {31'b0, RUN},      32'd0);
        chk("rst_ready", {31'b0, IN_READY}, 32'd0);
        chk("rst_busy",  {31'b0, BUSY},     32'd0);
        chk("rst_done",  {31'b0, DONE},     32'd0);
        chk("rst_err",   {31'b0, ERR},      32'd0);
        chk("rst_count", {23'b0, COUNT},    32'd0);
        chk("rst_out",   {24'b0, OUT},      32'd0);
        #4 CLEARn = 1'b1;
        tick();

        // Full-rate load of 3 bytes
        start_load();
        chk("hdr_busy", {31'b0, BUSY}, 32'd1);
        xfer(8'h03); xfer(8'hA1); xfer(8'hB2); xfer(8'hC3);
        finish_load();
        chk("l3_done",  {31'b0, DONE},     32'd1);
        chk("l3_run",   {31'b0, RUN},      32'd1);
        chk("l3_busy",  {31'b0, BUSY},     32'd0);
        chk("l3_ready", {31'b0, IN_READY}, 32'd0);
        chk("l3_count", {23'b0, COUNT},    32'd3);
        chk("l3_err",   {31'b0, ERR},      32'd0);
        rd("l3_a0", 8'h00, 8'hA1);
        rd("l3_a1", 8'h01, 8'hB2);
        rd("l3_a2", 8'h02, 8'hC3);
        rd("l3_a3", 8'h03, 8'h00);

        // HALT gates RUN combinationally
        HALT = 1'b1; #1;
        chk("halt_run",  {31'b0, RUN},  32'd0);
        chk("halt_done", {31'b0, DONE}, 32'd1);
        HALT = 1'b0; #1;
        chk("unhalt_run", {31'b0, RUN}, 32'd1);

        // Restart from RUNNING, then 256-byte image; START inside LOAD is ignored
        tick();
        START = 1'b1; tick(); START = 1'b0;
        tb_sum = 8'h00;
        chk("rs_done",  {31'b0, DONE},     32'd0);
        chk("rs_run",   {31'b0, RUN},      32'd0);
        chk("rs_ready", {31'b0, IN_READY}, 32'd1);
        xfer(8'h00);
        for (int i = 0; i < 256; i++) begin
            START = (i == 100);
            xfer(8'(i));
        end
        START = 1'b0;
        finish_load();
        chk("l256_count", {23'b0, COUNT}, 32'd256);
        chk("l256_done",  {31'b0, DONE},  32'd1);
        rd("l256_aff", 8'hFF, 8'hFF);
        rd("l256_a80", 8'h80, 8'h80);

        // IN_VALID toggling every other cycle
        start_load();
        xfer(8'h02); tick();
        chk("tg_count0", {23'b0, COUNT}, 32'd0);
        chk("tg_run0",   {31'b0, RUN},   32'd0);
        xfer(8'h11); tick();
        chk("tg_count1", {23'b0, COUNT}, 32'd1);
        chk("tg_run1",   {31'b0, RUN},   32'd0);
        xfer(8'h22);
        finish_load();
        tick();
        chk("tg_count2", {23'b0, COUNT}, 32'd2);
        chk("tg_done",   {31'b0, DONE},  32'd1);
        chk("tg_run2",   {31'b0, RUN},   32'd1);
        rd("tg_a0", 8'h00, 8'h11);
        rd("tg_a1", 8'h01, 8'h22);
        rd("tg_a2", 8'h02, 8'h00);

        // Asynchronous reset in the middle of LOAD
        start_load();
        xfer(8'h03); xfer(8'h77);
        chk("ml_count", {23'b0, COUNT}, 32'd1);
        #2 CLEARn = 1'b0;
        #1;
        chk("ml_run",   {31'b0, RUN},      32'd0);
        chk("ml_done",  {31'b0, DONE},     32'd0);
        chk("ml_busy",  {31'b0, BUSY},     32'd0);
        chk("ml_ready", {31'b0, IN_READY}, 32'd0);
        chk("ml_count0", {23'b0, COUNT},   32'd0);
        rd("ml_a0", 8'h00, 8'h00);
        rd("ml_a1", 8'h01, 8'h00);
        rd("ml_aff", 8'hFF, 8'h00);
        CLEARn = 1'b1;
        tick();

        // Single-byte image; same-cycle write shows the old word until the edge
        start_load();
        xfer(8'h01);
        IN_DATA = 8'h5A; IN_VALID = 1'b1;
        rd("wr_old", 8'h00, 8'h77);
        xfer(8'h5A);
        finish_load();
        chk("l1_done",  {31'b0, DONE},  32'd1);
        chk("l1_count", {23'b0, COUNT}, 32'd1);
        rd("l1_a0", 8'h00, 8'h5A);
        rd("l1_a1", 8'h01, 8'h00);

`ifdef PROG_LOADER_CHECKSUM_EN
        start_load();
        xfer(8'h02); xfer(8'h10); xfer(8'h20); xfer(8'hCE);
        chk("cs_ok_done", {31'b0, DONE}, 32'd1);
        chk("cs_ok_err",  {31'b0, ERR},  32'd0);
        rd("cs_ok_a1", 8'h01, 8'h20);
        start_load();
        xfer(8'h02); xfer(8'h10); xfer(8'h20); xfer(8'hCF);
        chk("cs_bad_err",   {31'b0, ERR},      32'd1);
        chk("cs_bad_done",  {31'b0, DONE},     32'd0);
        chk("cs_bad_run",   {31'b0, RUN},      32'd0);
        chk("cs_bad_ready", {31'b0, IN_READY}, 32'd0);
        rd("cs_bad_a0", 8'h00, 8'h00);
        tick();
        chk("cs_err_hold", {31'b0, ERR}, 32'd1);
        start_load();
        chk("cs_err_clr", {31'b0, ERR},  32'd0);
        chk("cs_busy",    {31'b0, BUSY}, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
